// File: rtl/mat_pair_loader_pkg.sv
// Shared constants and state encoding for the matrix pair loader.
package mat_pair_loader_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned N_ELEM = 9;
  localparam int unsigned MAT_W  = ELEM_W * N_ELEM;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/mat_pair_loader_if.sv
// Element-stream input and matrix-pair output bundle of the loader.
interface mat_pair_loader_if #(
  parameter int unsigned ELEM_W = mat_pair_loader_pkg::ELEM_W,
  parameter int unsigned N_ELEM = mat_pair_loader_pkg::N_ELEM
);

  localparam int unsigned MAT_W = ELEM_W * N_ELEM;

  logic [ELEM_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [MAT_W-1:0]  a_out;
  logic [MAT_W-1:0]  b_out;
  logic              out_valid;
  logic              out_ready;
  logic              loading_b;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, a_out, b_out, out_valid, loading_b
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, a_out, b_out, out_valid, loading_b
  );

endinterface

// File: rtl/mat_pair_loader.sv
// Collects an 18-element stream into packed 3x3 matrices A and B and
// presents them as one pair until the downstream multiplier takes it.
module mat_pair_loader #(
  parameter int unsigned ELEM_W = mat_pair_loader_pkg::ELEM_W,
  parameter int unsigned N_ELEM = mat_pair_loader_pkg::N_ELEM
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  mat_pair_loader_if.slave bus
);

  import mat_pair_loader_pkg::*;

  localparam int unsigned   MAT_BITS = ELEM_W * N_ELEM;
  localparam int unsigned   LSB_W    = $clog2(MAT_BITS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_ELEM - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [MAT_BITS-1:0]  a_q;
  logic [MAT_BITS-1:0]  b_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 loading_b_q;

  logic                 accept_c;
  logic                 last_c;
  logic [LSB_W-1:0]     lsb_c;

  // Element k lands in slot k counted from the MS end of the matrix word.
  always_comb begin
    accept_c = bus.in_valid && in_ready_q && !flush;
    last_c   = (cnt_q == LAST);
    cnt_d    = last_c ? '0 : cnt_q + CNT_W'(1);
    lsb_c    = LSB_W'(ELEM_W * (N_ELEM - 1 - 32'(cnt_q)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      loading_b_q <= 1'b0;
    end else if (flush) begin
      // Abort wins over accept and hand-off; matrix contents are kept.
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      loading_b_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (accept_c) begin
            a_q[lsb_c +: ELEM_W] <= bus.in_data;
            cnt_q                <= cnt_d;
            if (last_c) begin
              state_q     <= LOAD_B;
              loading_b_q <= 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (accept_c) begin
            b_q[lsb_c +: ELEM_W] <= bus.in_data;
            cnt_q                <= cnt_d;
            if (last_c) begin
              state_q     <= HOLD;
              loading_b_q <= 1'b0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q     <= LOAD_A;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= LOAD_A;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          loading_b_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.loading_b = loading_b_q;
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;

endmodule

// File: doc/mat_pair_loader.md
MAT_PAIR_LOADER -- requirements
Module: mat_pair_loader

Interface
REQ-001 Parameter ELEM_W, default 8: width of one matrix element in bits.
REQ-002 Parameter N_ELEM, default 9: elements per matrix (3x3, row-major).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 flush  input  1  synchronous abort; discards the partial or held pair.
REQ-006 in_data  input  ELEM_W  one element of the incoming stream.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  the loader accepts in_data this cycle.
REQ-009 a_out  output  ELEM_W*N_ELEM (72)  packed matrix A; [0][0] in the MS byte, [2][2] in the LS byte.
REQ-010 b_out  output  ELEM_W*N_ELEM (72)  packed matrix B, same packing as a_out.
REQ-011 out_valid  output  1  a_out and b_out hold a complete pair.
REQ-012 out_ready  input  1  the downstream multiplier consumes the pair this cycle.
REQ-013 loading_b  output  1  high while B elements are being collected (status/debug).

Function
REQ-014 The element stream SHALL be 18 elements per pair: 9 A elements, row-major, then 9 B elements, row-major.
REQ-015 An element SHALL be accepted exactly on a cycle where in_valid and in_ready are both high.
REQ-016 The FSM SHALL have three states: LOAD_A, LOAD_B and HOLD.
REQ-017 Reset state SHALL be LOAD_A.
REQ-018 LOAD_A SHALL go to LOAD_B when the 9th A element is accepted.
REQ-019 LOAD_B SHALL go to HOLD when the 9th B element is accepted.
REQ-020 HOLD SHALL go to LOAD_A on a cycle where out_valid and out_ready are both high.
REQ-021 A 4-bit element counter SHALL count 0..8: it increments on each accept, wraps to 0 on the 9th accept of each matrix, and SHALL never hold a value of 9 or more.
REQ-022 Accepted element k (k = 0..8) SHALL be written to bits [ELEM_W*(9-k)-1 : ELEM_W*(8-k)] of the target register.
REQ-023 in_ready SHALL be high in LOAD_A and LOAD_B and low in HOLD (and not depend combinationally on in_valid).
REQ-024 out_valid SHALL be high only in HOLD.
REQ-025 out_valid SHALL rise the cycle after the 18th element is accepted (latency 1).
REQ-026 Minimum period per pair SHALL be 19 cycles.
REQ-027 a_out and b_out SHALL be stable while out_valid is high and out_ready is low.
REQ-028 Registers SHALL not be cleared between pairs; only slots being written change.
REQ-029 loading_b SHALL equal (state == LOAD_B).
REQ-030 flush SHALL set the state to LOAD_A and the counter to 0 on the next edge, and out_valid SHALL be low on the next cycle.
REQ-031 flush SHALL take priority over a simultaneous accept and over a simultaneous out_valid && out_ready.
REQ-032 If flush and in_valid are high together, that element SHALL be dropped.
REQ-033 flush SHALL leave the a_out and b_out contents unchanged.
REQ-034 Gaps in in_valid SHALL stall loading without any loss of state.
REQ-035 out_ready asserted outside HOLD SHALL have no effect.

Reset
REQ-036 On rst, asynchronously: state = LOAD_A, counter = 0, a_out = 0, b_out = 0, out_valid = 0, loading_b = 0.
REQ-037 During reset and in the first cycle after release, in_ready SHALL be 1 (LOAD_A); no element is accepted while rst is high.
REQ-038 rst asserted mid-load or during HOLD SHALL discard the pair; the pair SHALL not be presented after release.

Structure
REQ-039 A shared package SHALL hold: ELEM_W, N_ELEM, the matrix width constant (ELEM_W*N_ELEM), and the state encoding localparams/typedef (LOAD_A, LOAD_B, HOLD).
REQ-040 The block SHALL be a single module with no sub-modules; the packed-register write SHALL be one indexed part-select per matrix.

Verification
REQ-041 Stream A = 1..9 (0x01..0x09), then B = 0x10..0x18, with in_valid held high and out_ready high -> out_valid rises on cycle 19; a_out = 0x010203040506070809; b_out = 0x101112131415161718; out_valid falls on cycle 20.
REQ-042 Same stream with out_ready low for 5 cycles after out_valid -> outputs stay stable, in_ready stays 0 throughout, and the pair is released on the first cycle out_ready is high.
REQ-043 Random in_valid gaps (about 50% duty) with A = all 0xFF and B = all 0x01 -> a_out = 72'hFF..FF, b_out = 72'h01..01, and no element is dropped or duplicated.
REQ-044 flush asserted after the 12th accept (with in_valid high in the same cycle) -> loading_b = 0 and the counter = 0 next cycle; a fresh 18-element stream produces the correct pair.
REQ-045 rst pulse during HOLD -> out_valid, a_out and b_out read 0 immediately (asynchronous); in_ready = 1 after release.
REQ-046 Two back-to-back pairs with out_ready tied high -> the second out_valid appears exactly 19 cycles after the first.
